// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter slice.
//   XLEN       : result data width carried in a buffered writeback request
//   REG_ADDR_W : register file address width
//   REG_ZERO   : architectural zero register (writes to it are dropped)
//   wb_req_t   : one buffered writeback request {rd, data}
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t used to buffer long-latency results.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write an entry at the tail (ignored when full)
//   pop, pop_data   : pop_data is the head entry; pop removes it (ignored when empty)
//   full, empty     : occupancy flags derived from the registered count
//   count           : number of stored entries, 0..DEPTH
// DEPTH must be a power of two (pointers wrap by natural overflow), at least 2.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t         mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: drives the register file write port (a3/we3/wd3).
// Merges the single-cycle ALU stream with a ready/valid long-latency stream.
// Long-latency results wait in a wb_fifo; a starvation guard raises alu_stall
// so that a waiting FIFO head is always drained.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       : ALU result
//   alu_accept                      : ALU result consumed this cycle
//   alu_stall                       : registered; upstream holds the ALU result
//   ll_valid/ll_ready/ll_rd/ll_data : long-latency ready/valid input
//   we3/a3/wd3                      : registered register file write
//   ll_pending                      : FIFO non-empty
// Optional macro WB_BYPASS_EN adds fwd_rs1/2 inputs and fwd_hit1/2,
// fwd_data1/2 outputs covering the same-cycle write/read window.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_accept,
    output logic            alu_stall,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            ll_pending
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]      fwd_rs1,
    input  logic [4:0]      fwd_rs2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Wide enough to hold STARVE_LIMIT + 1 without wrapping.
    localparam int SW    = $clog2(STARVE_LIMIT + 1) + 1;

    wb_req_t          push_req_s;
    wb_req_t          head_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;

    logic             sel_valid_s;
    logic [4:0]       sel_rd_s;
    logic [XLEN-1:0]  sel_data_s;
    logic             we_next_s;

    logic [SW-1:0]    cnt_r;
    logic [SW-1:0]    cnt_inc_s;
    logic [SW-1:0]    cnt_next_s;
    logic             stall_next_s;

    logic             we3_r;
    logic [4:0]       a3_r;
    logic [XLEN-1:0]  wd3_r;
    logic             alu_stall_r;

    assign push_req_s.rd   = ll_rd;
    assign push_req_s.data = ll_data;

    assign ll_ready   = (count_s < CNT_W'(FIFO_DEPTH));
    assign ll_pending = ~empty_s;
    assign push_s     = ll_valid & ~full_s;
    assign alu_accept = alu_valid & ~alu_stall_r;
    // The FIFO head only wins when the ALU is not consumed; a same-cycle push
    // into an empty FIFO is not visible yet, so there is no flow-through.
    assign pop_s      = ~alu_accept & ~empty_s;

    wb_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_req_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Source selection: ALU first, then FIFO head, else nothing.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_rd_s    = REG_ZERO;
        sel_data_s  = {XLEN{1'b0}};
        if (alu_accept) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = alu_rd;
            sel_data_s  = alu_data;
        end else if (!empty_s) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = head_s.rd;
            sel_data_s  = head_s.data;
        end else begin
            sel_valid_s = 1'b0;
        end
        // A consumed write to x0 is dropped here, leaving a3/wd3 untouched.
        we_next_s = sel_valid_s & (sel_rd_s != REG_ZERO);
    end

    // Starvation counter: counts cycles the head waits without being popped.
    always_comb begin
        cnt_inc_s    = cnt_r + SW'(1);
        cnt_next_s   = {SW{1'b0}};
        stall_next_s = 1'b0;
        if (empty_s || pop_s) begin
            cnt_next_s   = {SW{1'b0}};
            stall_next_s = 1'b0;
        end else begin
            cnt_next_s   = cnt_inc_s;
            stall_next_s = (cnt_inc_s >= SW'(STARVE_LIMIT));
        end
    end

    // Output write port and starvation state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_r       <= 1'b0;
            a3_r        <= 5'd0;
            wd3_r       <= {XLEN{1'b0}};
            alu_stall_r <= 1'b0;
            cnt_r       <= {SW{1'b0}};
        end else begin
            we3_r       <= we_next_s;
            if (we_next_s) begin
                a3_r  <= sel_rd_s;
                wd3_r <= sel_data_s;
            end
            alu_stall_r <= stall_next_s;
            cnt_r       <= cnt_next_s;
        end
    end

    assign we3       = we3_r;
    assign a3        = a3_r;
    assign wd3       = wd3_r;
    assign alu_stall = alu_stall_r;

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to readers of the same register this cycle.
    assign fwd_hit1  = we3_r & (a3_r == fwd_rs1) & (fwd_rs1 != REG_ZERO);
    assign fwd_hit2  = we3_r & (a3_r == fwd_rs2) & (fwd_rs2 != REG_ZERO);
    assign fwd_data1 = fwd_hit1 ? wd3_r : {XLEN{1'b0}};
    assign fwd_data2 = fwd_hit2 ? wd3_r : {XLEN{1'b0}};
`endif

endmodule
